seg_frame_gen: RTL and testbench

SEG_FRAME_GEN -- requirements
Module: seg_frame_gen

---
 rtl/seg_frame_gen.sv | 102 ++++++++++
 tb/tb_seg_frame_gen.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/seg_frame_gen.sv
// seg_frame_gen: double-buffered 7-segment frame builder with tick-aligned commit and blink
module seg_frame_gen #(
    parameter int DIGITS    = 8,
    parameter int TICK_BITS = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_raw_mode,
    input  logic [4*DIGITS-1:0]   in_hex,
    input  logic [8*DIGITS-1:0]   in_raw,
    input  logic [DIGITS-1:0]     in_dp,
    input  logic [DIGITS-1:0]     in_blank,
    input  logic [DIGITS-1:0]     in_blink,
    output logic [8*DIGITS-1:0]   pdata,
    output logic                  committed
);
    typedef enum logic {IDLE, PENDING} state_t;
    localparam logic [6:0] SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    state_t                state;
    logic [TICK_BITS-1:0]  presc;
    logic                  tick;
    logic                  blink_phase;
    logic                  s_raw_mode, a_raw_mode;
    logic [4*DIGITS-1:0]   s_hex, a_hex;
    logic [8*DIGITS-1:0]   s_raw, a_raw;
    logic [DIGITS-1:0]     s_dp, a_dp, s_blank, a_blank, s_blink, a_blink;
    logic [8*DIGITS-1:0]   frame;
    assign tick = &presc;
    assign in_ready = (state == IDLE) && !rst;
    // free-running prescaler and blink phase that flips on every wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            presc       <= '0;
            blink_phase <= 1'b0;
        end else begin
            presc <= presc + 1'b1;
            if (tick)
                blink_phase <= ~blink_phase;
        end
    end
    // accept into the shadow when idle, promote shadow to active on the next tick
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            committed  <= 1'b0;
            s_raw_mode <= 1'b0;
            s_hex      <= '0;
            s_raw      <= '0;
            s_dp       <= '0;
            s_blank    <= '1;
            s_blink    <= '0;
            a_raw_mode <= 1'b0;
            a_hex      <= '0;
            a_raw      <= '0;
            a_dp       <= '0;
            a_blank    <= '1;
            a_blink    <= '0;
        end else begin
            committed <= 1'b0;
            if (state == IDLE) begin
                if (in_valid) begin
                    s_raw_mode <= in_raw_mode;
                    s_hex      <= in_hex;
                    s_raw      <= in_raw;
                    s_dp       <= in_dp;
                    s_blank    <= in_blank;
                    s_blink    <= in_blink;
                    state      <= PENDING;
                end
            end else if (tick) begin
                a_raw_mode <= s_raw_mode;
                a_hex      <= s_hex;
                a_raw      <= s_raw;
                a_dp       <= s_dp;
                a_blank    <= s_blank;
                a_blink    <= s_blink;
                committed  <= 1'b1;
                state      <= IDLE;
            end
        end
    end
    // per-digit segment byte: blank beats blink, raw bytes bypass decode and dp
    always_comb begin
        frame = '1;
        for (int i = 0; i < DIGITS; i++)
            frame[8*i +: 8] = (a_blank[i] || (a_blink[i] && blink_phase)) ? 8'hFF :
                              a_raw_mode ? a_raw[8*i +: 8] :
                              {~a_dp[i], SEG[a_hex[4*i +: 4]]};
    end
    // register the frame so the shifter sees a glitch-free, stable word
    always_ff @(posedge clk) begin
        if (rst)
            pdata <= '1;
        else
            pdata <= frame;
    end
endmodule

// File: tb/tb_seg_frame_gen.sv
// tb_seg_frame_gen: randomized scoreboard bench for seg_frame_gen (DIGITS=8, TICK_BITS=4)
module tb_seg_frame_gen;
    localparam int D = 8;
    localparam int TB = 4;
    localparam int PER = 1 << TB;

    logic clk = 0, rst = 1, in_valid = 0, in_ready, in_raw_mode = 0, committed;
    logic [4*D-1:0] in_hex = '0;
    logic [8*D-1:0] in_raw = '0, pdata;
    logic [D-1:0] in_dp = '0, in_blank = '0, in_blink = '0;

    seg_frame_gen #(.DIGITS(D), .TICK_BITS(TB)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_raw_mode(in_raw_mode), .in_hex(in_hex), .in_raw(in_raw),
        .in_dp(in_dp), .in_blank(in_blank), .in_blink(in_blink),
        .pdata(pdata), .committed(committed)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            raw_mode;
        logic [4*D-1:0] hex;
        logic [8*D-1:0] raw;
        logic [D-1:0]  dp, blank, blink;
        int            acc;
    } frame_t;

    logic [7:0] lut [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    int total = 0, bad = 0, cyc = 0;
    bit started = 0, prev_rst = 1;
    frame_t q[$];
    frame_t act;
    logic [8*D-1:0] exp_p = '1;

    // cycle index since reset release; equals the expected prescaler count mod PER
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    function automatic frame_t mk(bit rm, logic [4*D-1:0] h, logic [8*D-1:0] r,
                                  logic [D-1:0] dp, logic [D-1:0] bl, logic [D-1:0] bk);
        frame_t f;
        f.raw_mode = rm; f.hex = h; f.raw = r; f.dp = dp; f.blank = bl; f.blink = bk; f.acc = 0;
        return f;
    endfunction

    function automatic frame_t rnd_frame();
        return mk(1'($urandom), $urandom, {$urandom, $urandom}, 8'($urandom),
                  8'($urandom & $urandom), 8'($urandom));
    endfunction

    // expected display word for a frame shown with the given blink phase
    function automatic logic [8*D-1:0] enc(frame_t f, bit ph);
        logic [8*D-1:0] r;
        logic [7:0] l;
        for (int i = 0; i < D; i++) begin
            l = lut[f.hex[4*i +: 4]];
            r[8*i +: 8] = f.blank[i] ? 8'hFF : (f.blink[i] && ph) ? 8'hFF :
                          f.raw_mode ? f.raw[8*i +: 8] : {~f.dp[i], l[6:0]};
        end
        return r;
    endfunction

    // the tick cycle on which a frame accepted in cycle c is promoted
    function automatic int commit_tick(int c);
        return (c % PER == PER - 1) ? c + PER : (c / PER) * PER + PER - 1;
    endfunction

    task automatic chk(string name, logic [63:0] got, logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, got, want, cyc);
        end
    endtask

    // monitor: pops the scoreboard on every committed pulse and checks outputs each cycle
    always @(negedge clk) begin
        frame_t f;
        if (started) begin
            if (rst) begin
                chk("rst_in_ready", 64'(in_ready), 64'(0));
                if (prev_rst) begin
                    chk("rst_pdata", pdata, '1);
                    chk("rst_committed", 64'(committed), 64'(0));
                end
                q.delete();
                act = mk(0, '0, '0, '0, '1, '0);
                exp_p = '1;
            end else begin
                if (committed) begin
                    if (q.size() == 0)
                        chk("spurious_commit", 64'(committed), 64'(0));
                    else begin
                        f = q.pop_front();
                        chk("commit_cycle", 64'(cyc), 64'(commit_tick(f.acc) + 1));
                        act = f;
                    end
                end else if (q.size() > 0 && commit_tick(q[0].acc) + 1 < cyc) begin
                    chk("commit_timeout", 64'(committed), 64'(1));
                    f = q.pop_front();
                end
                chk("pdata", pdata, exp_p);
                chk("in_ready", 64'(in_ready), 64'(q.size() == 0 || q[0].acc >= cyc));
                exp_p = enc(act, 1'((cyc / PER) % 2));
            end
            prev_rst = rst;
        end
    end

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // offer a frame once in_ready is up (and, if at >= 0, the prescaler equals at)
    task automatic send(frame_t f, int at);
        int n = 0;
        while (!(in_ready && (at < 0 || cyc % PER == at))) begin
            step(1);
            if (++n > 200) begin
                total++; bad++;
                $display("FAIL send_wait: in_ready=%b never usable by cycle %0d", in_ready, cyc);
                return;
            end
        end
        in_valid = 1; in_raw_mode = f.raw_mode; in_hex = f.hex; in_raw = f.raw;
        in_dp = f.dp; in_blank = f.blank; in_blink = f.blink;
        f.acc = cyc;
        q.push_back(f);
        step(1);
        in_valid = 0; in_hex = $urandom; in_raw = {$urandom, $urandom};
        in_dp = 8'($urandom); in_blank = 8'($urandom); in_blink = 8'($urandom);
    endtask

    task automatic pulse_reset(int n);
        rst = 1;
        step(n);
        rst = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1);
    end

    initial begin
        @(posedge clk); #1;
        started = 1;
        step(2);
        rst = 0;
        step(40);
        send(mk(0, 32'h7654_3210, '0, '0, '0, '0), 3);
        in_valid = 1;
        step(5);
        in_valid = 0;
        step(30);
        chk("hex_literal", pdata, 64'hF882_9299_B0A4_F9C0);
        send(mk(0, 32'hFEDC_BA98, '0, 8'hA5, '0, '0), PER - 1);
        step(40);
        send(mk(0, 32'h0000_0008, '0, '0, '0, 8'h01), -1);
        step(5 * PER);
        send(mk(1, '0, 64'h0102_0304_0506_073C, '0, 8'h01, '0), -1);
        step(40);
        chk("raw_blank_literal", 64'(pdata[7:0]), 64'hFF);
        send(mk(1, '0, 64'h0102_0304_0506_073C, '0, '0, '0), -1);
        step(40);
        chk("raw_literal", 64'(pdata[7:0]), 64'h3C);
        send(rnd_frame(), 2);
        step(3);
        pulse_reset(3);
        step(40);
        chk("post_rst_literal", pdata, '1);
        for (int k = 0; k < 30; k++) begin
            send(rnd_frame(), ($urandom_range(0, 3) == 0) ? PER - 1 : -1);
            step($urandom_range(0, 20));
            if (k == 15) pulse_reset($urandom_range(1, 3));
        end
        step(3 * PER);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
